// File: rtl/noc_buf_ctrl.sv
// Input-buffer controller that drives a level-sensitive dual-port flit RAM and presents it as a single-clock FIFO.
// Optional high-water-mark tracking (hwm / hwm_clr ports) is built when NOC_BUF_HWM_EN is defined.
module noc_buf_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic [DATA_WIDTH-1:0] ram_wdata_0,
  output logic                  ram_cs_0,
  output logic                  ram_we_0,
  output logic                  ram_oe_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  input  logic [DATA_WIDTH-1:0] ram_rdata_1,
  output logic                  ram_cs_1,
  output logic                  ram_we_1,
  output logic                  ram_oe_1,
  output logic [ADDR_WIDTH:0]   level
`ifdef NOC_BUF_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm,
  input  logic                  hwm_clr
`endif
);

  localparam int                   CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                               input logic             inc,
                                               input logic             dec);
    logic [CNT_W-1:0] r;
    r = c;
    case ({inc, dec})
      2'b10:   r = c + 1'b1;
      2'b01:   r = c - 1'b1;
      default: r = c;
    endcase
    return r;
  endfunction

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_alloc;
  logic [CNT_W-1:0]      r_ready_cnt;
  logic                  r_wr_pend;
  logic [ADDR_WIDTH-1:0] r_wr_addr_p0;
  logic [DATA_WIDTH-1:0] r_wr_data_p0;
  logic                  r_out_vld_p1;
  logic [DATA_WIDTH-1:0] r_out_data_p1;

  logic w_in_ready;
  logic w_push;
  logic w_rd_avail;
  logic w_load;
  logic w_pop_only;

  // Credit comes only from the registered slot count; a same-cycle load does not free a slot early.
  assign w_in_ready = (r_alloc < DEPTH_C);
  assign w_push     = in_valid & w_in_ready;
  assign w_rd_avail = (r_ready_cnt != '0);
  assign w_load     = w_rd_avail & (~r_out_vld_p1 | out_ready);
  assign w_pop_only = r_out_vld_p1 & out_ready & ~w_load;

  // Write stage: capture address/data at the push edge and hold them across the whole enable-high cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_wr_pend    <= 1'b0;
      r_wr_addr_p0 <= '0;
      r_wr_data_p0 <= '0;
    end else begin
      r_wr_pend <= w_push;
      if (w_push) begin
        r_wr_addr_p0 <= r_wr_ptr;
        r_wr_data_p0 <= in_data;
        r_wr_ptr     <= ptr_inc(r_wr_ptr);
      end
    end
  end

  // Occupancy: ready_cnt only counts entries whose write cycle has completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alloc     <= '0;
      r_ready_cnt <= '0;
    end else begin
      r_alloc     <= cnt_upd(r_alloc, w_push, w_load);
      r_ready_cnt <= cnt_upd(r_ready_cnt, r_wr_pend, w_load);
    end
  end

  // Output stage: head flit register fed from the asynchronous read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_out_vld_p1  <= 1'b0;
      r_out_data_p1 <= '0;
    end else begin
      if (w_load) begin
        r_out_data_p1 <= ram_rdata_1;
        r_out_vld_p1  <= 1'b1;
        r_rd_ptr      <= ptr_inc(r_rd_ptr);
      end else if (w_pop_only) begin
        r_out_vld_p1  <= 1'b0;
      end
    end
  end

`ifdef NOC_BUF_HWM_EN
  logic [CNT_W-1:0] r_hwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hwm <= '0;
    end else if (hwm_clr) begin
      r_hwm <= r_alloc;
    end else if (r_alloc > r_hwm) begin
      r_hwm <= r_alloc;
    end
  end

  assign hwm = r_hwm;
`endif

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_vld_p1;
  assign out_data      = r_out_data_p1;
  assign level         = r_alloc;

  assign ram_address_0 = r_wr_addr_p0;
  assign ram_wdata_0   = r_wr_data_p0;
  assign ram_cs_0      = r_wr_pend;
  assign ram_we_0      = r_wr_pend;
  assign ram_oe_0      = 1'b0;

  assign ram_address_1 = r_rd_ptr;
  assign ram_cs_1      = w_rd_avail;
  assign ram_oe_1      = w_rd_avail;
  assign ram_we_1      = 1'b0;

endmodule

// File: tb/tb_noc_buf_ctrl.sv
// Scoreboard bench for noc_buf_ctrl with a behavioural level-sensitive dual-port RAM.
module tb_noc_buf_ctrl;
  localparam int DW = 12;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] ram_address_0;
  logic [DW-1:0] ram_wdata_0;
  logic          ram_cs_0, ram_we_0, ram_oe_0;
  logic [AW-1:0] ram_address_1;
  logic [DW-1:0] ram_rdata_1;
  logic          ram_cs_1, ram_we_1, ram_oe_1;
  logic [AW:0]   level;
`ifdef NOC_BUF_HWM_EN
  logic [AW:0]   hwm;
  logic          hwm_clr = 1'b0;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sb_q [$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_push = 0;
  int            n_pop = 0;
  bit            mon_en = 1'b0;

  noc_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_address_0(ram_address_0), .ram_wdata_0(ram_wdata_0),
    .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
    .ram_address_1(ram_address_1), .ram_rdata_1(ram_rdata_1),
    .ram_cs_1(ram_cs_1), .ram_we_1(ram_we_1), .ram_oe_1(ram_oe_1),
    .level(level)
`ifdef NOC_BUF_HWM_EN
    , .hwm(hwm), .hwm_clr(hwm_clr)
`endif
  );

  always #5 clk = ~clk;

  // RAM: write lands mid-cycle while enables are high; read is combinational.
  always @(negedge clk) begin
    if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_wdata_0;
  end
  assign ram_rdata_1 = (ram_cs_1 && ram_oe_1) ? mem[ram_address_1] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_occupancy", 32'(sb_q.size()), 32'd1);
        else check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
        n_pop++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        n_push++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !(level == 0 && !out_valid && sb_q.size() == 0); i++) tick();
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_oval"}, 32'(out_valid), 32'd0);
    check({tag, "_sbq"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  acc;
    bit  rdy;
    int  idx, first, last, nout;
    bit  wrap0, wrap1;
    logic [AW-1:0] prev0, prev1;
    int  base_push;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_addr0", 32'(ram_address_0), 32'd0);
    check("rst_addr1", 32'(ram_address_1), 32'd0);
    check("rst_wdata0", 32'(ram_wdata_0), 32'd0);
    check("rst_ctl", 32'({ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1}), 32'd0);
`ifdef NOC_BUF_HWM_EN
    check("rst_hwm", 32'(hwm), 32'd0);
`endif
    mon_en = 1'b1;

    // Single flit latency
    in_data = 12'hA5C; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t2_cs0", 32'(ram_cs_0), 32'd1);
    check("t2_we0", 32'(ram_we_0), 32'd1);
    check("t2_addr0", 32'(ram_address_0), 32'd0);
    check("t2_wdata0", 32'(ram_wdata_0), 32'hA5C);
    tick();
    check("t2_oval_c2", 32'(out_valid), 32'd0);
    tick();
    check("t2_oval_c3", 32'(out_valid), 32'd1);
    check("t2_odata_c3", 32'(out_data), 32'hA5C);
    tick();
    check("t2_oval_c4", 32'(out_valid), 32'd0);
    check("t2_level_c4", 32'(level), 32'd0);

    // Fill with output stalled
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'(12'h100 + acc);
      rdy = in_ready;
      tick();
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    check("t3_accepted", 32'(acc), 32'd9);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_level", 32'(level), 32'd8);
    check("t3_oval", 32'(out_valid), 32'd1);
    check("t3_odata", 32'(out_data), 32'h100);
`ifdef NOC_BUF_HWM_EN
    check("t3_hwm", 32'(hwm), 32'd8);
`endif
    drain("t3_drain");

    // Streaming with wrap
    idx = 0; first = -1; last = -1; nout = 0; wrap0 = 1'b0; wrap1 = 1'b0;
    prev0 = ram_address_0; prev1 = ram_address_1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 20);
      in_data  = DW'(idx + 1);
      rdy = in_valid && in_ready;
      tick();
      if (rdy) idx++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      if (prev0 == 3'd7 && ram_address_0 == 3'd0) wrap0 = 1'b1;
      if (prev1 == 3'd7 && ram_address_1 == 3'd0) wrap1 = 1'b1;
      prev0 = ram_address_0; prev1 = ram_address_1;
    end
    in_valid = 1'b0;
    check("t4_pushed", 32'(idx), 32'd20);
    check("t4_outputs", 32'(nout), 32'd20);
    check("t4_no_bubble", 32'(last - first + 1), 32'd20);
    check("t4_wrap0", 32'(wrap0), 32'd1);
    check("t4_wrap1", 32'(wrap1), 32'd1);
    drain("t4_drain");

    // Full buffer, single-cycle downstream pulse
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'(12'h200 + i);
      tick();
    end
    check("t5_full_level", 32'(level), 32'd8);
    check("t5_full_ready", 32'(in_ready), 32'd0);
    base_push = n_push;
    in_data = 12'h2FF; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_ready_up", 32'(in_ready), 32'd1);
    check("t5_level7", 32'(level), 32'd7);
    tick();
    check("t5_ready_down", 32'(in_ready), 32'd0);
    check("t5_level8", 32'(level), 32'd8);
    tick();
    in_valid = 1'b0;
    check("t5_one_accept", 32'(n_push - base_push), 32'd1);
    drain("t5_drain");
    check("t5_push_pop", 32'(n_pop), 32'(n_push));

    // Reset during an active write
    in_data = 12'h777; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("t6_we_before", 32'(ram_we_0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_cs0_async", 32'(ram_cs_0), 32'd0);
    check("t6_we0_async", 32'(ram_we_0), 32'd0);
    sb_q.delete();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t6_oval", 32'(out_valid), 32'd0);
    check("t6_level", 32'(level), 32'd0);
`ifdef NOC_BUF_HWM_EN
    check("t6_hwm", 32'(hwm), 32'd0);
`endif
    in_data = 12'h3C3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("t6_oval_new", 32'(out_valid), 32'd1);
    check("t6_odata_new", 32'(out_data), 32'h3C3);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/noc_buf_ctrl.md
Name: noc_buf_ctrl

Overview:
- Input-buffer controller for a router port; sits directly upstream of the dual-port asynchronous RAM (flit store) and drives both of its ports.
- Accepts flits from the link with a valid/ready handshake and writes them through RAM port 0.
- Reads them back in order through RAM port 1 into a registered output stage that feeds the route/arbitration logic with valid/ready.
- Converts the RAM's level-sensitive asynchronous write/read into clean single-clock FIFO behaviour.

Parameters:
- DATA_WIDTH, 12, flit width; equals RAM data width.
- ADDR_WIDTH, 3, RAM address width.
- RAM_DEPTH, 8, RAM entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  buffer can accept a flit this cycle.
- in_data  input  DATA_WIDTH  upstream flit.
- out_valid  output  1  out_data holds a flit.
- out_ready  input  1  downstream consumes the flit.
- out_data  output  DATA_WIDTH  registered head flit.
- ram_address_0  output  ADDR_WIDTH  write address to RAM port 0.
- ram_wdata_0  output  DATA_WIDTH  write data; top level drives RAM data_0 with it.
- ram_cs_0, ram_we_0, ram_oe_0  output  1 each  port 0 controls; ram_oe_0 tied 0.
- ram_address_1  output  ADDR_WIDTH  read address to RAM port 1.
- ram_rdata_1  input  DATA_WIDTH  RAM data_1 as seen by the controller.
- ram_cs_1, ram_we_1, ram_oe_1  output  1 each  port 1 controls; ram_we_1 tied 0.
- level  output  ADDR_WIDTH+1  allocated RAM slots, 0..RAM_DEPTH.

Behaviour:
- Reset (async, immediate): wr_ptr, rd_ptr, alloc, ready_cnt = 0. wr_pend = 0. out_valid = 0, out_data = 0. ram_address_0/1 = 0, ram_wdata_0 = 0. All ram_cs/we/oe = 0. in_ready = 1 once reset is released. RAM contents are not cleared.
- Push: push = in_valid & in_ready, with in_ready = (alloc < RAM_DEPTH).
  - in_ready uses only the registered alloc. No same-cycle credit from a pop.
  - On a push edge: ram_address_0 <= wr_ptr, ram_wdata_0 <= in_data, wr_pend <= 1, wr_ptr <= wr_ptr+1 (wraps mod RAM_DEPTH).
- Write commit: ram_cs_0 = ram_we_0 = wr_pend, driven from flops.
  - Address and data are held stable for the whole high cycle, which the level-sensitive RAM write requires.
  - wr_pend clears next edge unless another push occurs. Back-to-back pushes keep cs/we high while address and data change at the edge.
- ready_cnt counts committed, unread entries. It increments on the edge ending a wr_pend cycle, so a pending write is never readable.
- Read port: ram_address_1 = rd_ptr (registered). ram_cs_1 = ram_oe_1 = (ready_cnt != 0).
- load = (ready_cnt != 0) & (!out_valid | out_ready). On load: out_data <= ram_rdata_1, out_valid <= 1, rd_ptr <= rd_ptr+1 (wraps).
- Pop without load: out_valid & out_ready & !load sets out_valid <= 0. out_data holds its value.
- Counter updates:
  - alloc += push − load.
  - ready_cnt += wr_pend − load.
  - level = alloc.
- Capacity and throughput: total capacity is RAM_DEPTH+1 (RAM plus output register). Steady-state throughput is 1 flit/cycle.
- Latency: push accepted at edge N → RAM write during cycle N+1 → loaded at edge N+2 → out_valid high in cycle N+3 (3-cycle empty-buffer latency).
- Boundaries:
  - Full (alloc = RAM_DEPTH): in_ready = 0. in_data is ignored.
  - Simultaneous push and load at alloc = RAM_DEPTH−1: both occur and alloc stays at RAM_DEPTH−1.
  - Empty: ram_cs_1 = 0 and no load occurs.
  - Ordering is strictly FIFO across pointer wrap.
  - Write address and read address never collide with a readable entry, because ready_cnt excludes wr_pend.
- Reset mid-operation: ram_cs_0/ram_we_0 drop asynchronously. Any pending write is abandoned and the buffer restarts empty.

Optional Feature:
- Macro NOC_BUF_HWM_EN.
- When defined: adds output port hwm (ADDR_WIDTH+1) and input port hwm_clr (1).
  - hwm registers the maximum alloc seen since reset or since the last hwm_clr.
  - hwm_clr loads the current alloc on that edge.
  - hwm resets to 0.
- When undefined: neither port exists and there is no extra logic.

Test Plan:
1. Hold reset high, then release → all outputs 0 except in_ready = 1 after release. level = 0.
2. Single push 0xA5C at edge 0, out_ready = 1:
   - cycle 1: ram_cs_0 = ram_we_0 = 1, ram_address_0 = 0, ram_wdata_0 = 0xA5C.
   - cycle 3: out_valid = 1, out_data = 0xA5C.
   - next cycle: out_valid = 0, level = 0.
3. Push continuously with out_ready = 0 → exactly 9 flits accepted. in_ready falls after the 9th with level = 8, and out_data = first flit.
4. Stream 20 flits 0x001..0x014 with in_valid = out_ready = 1 → outputs appear in order. ram_address_0/1 wrap 7→0. After the initial latency, one flit per cycle with no bubbles.
5. Full buffer, out_ready pulsed for one cycle while in_valid = 1 → in_ready rises one cycle later, one flit is accepted, level returns to 8, and no flit is lost or duplicated.
6. Assert reset during a cycle with ram_we_0 = 1 → ram_cs_0/ram_we_0 drop in the same cycle. After release: out_valid = 0, level = 0, and a new push of 0x3C3 appears as the first output. With NOC_BUF_HWM_EN defined, hwm = 0 after reset and 8 after test 3.
